// File: rtl/invert_pkg.sv
// Shared types and helpers for the bit-serial two's-complement unit.
package invert_pkg;

  typedef enum logic {
    COPY   = 1'b0,
    INVERT = 1'b1
  } state_t;

  // Bit-counter width for a given word length; 1 keeps the type legal when no counter is built.
  function automatic int cnt_width(input int word_len);
    if (word_len > 0) begin
      return $clog2(word_len + 1);
    end
    return 1;
  endfunction

endpackage

// File: rtl/invert_word_ctr.sv
// Modulo-WORD_LEN bit counter; wrap is high during the cycle that presents the last bit of a word.
module invert_word_ctr
  import invert_pkg::*;
#(
  parameter int unsigned WORD_LEN = 4
) (
  input  logic                         t_clk,
  input  logic                         r,
  output logic [cnt_width(WORD_LEN)-1:0] count,
  output logic                         wrap
);

  localparam int CW = cnt_width(WORD_LEN);
  localparam logic [CW-1:0] LAST = CW'(WORD_LEN - 1);

  logic [CW-1:0] count_q;

  assign wrap  = (count_q == LAST);
  assign count = count_q;

  always_ff @(posedge t_clk or negedge r) begin
    if (!r) begin
      count_q <= '0;
    end else if (wrap) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/invert.sv
// Bit-serial two's complement, LSB first: copy bits up to and including the first 1, invert the rest.
module invert
  import invert_pkg::*;
#(
  parameter int unsigned WORD_LEN = 0
) (
  input  logic   t_clk,
  input  logic   r,
  input  logic   i,
  output logic   y,
  output state_t state
);

  state_t state_q;
  state_t state_d;
  logic   wrap;

  generate
    if (WORD_LEN > 0) begin : g_ctr
      logic [cnt_width(WORD_LEN)-1:0] count;

      invert_word_ctr #(
        .WORD_LEN(WORD_LEN)
      ) u_word_ctr (
        .t_clk(t_clk),
        .r    (r),
        .count(count),
        .wrap (wrap)
      );
    end else begin : g_no_ctr
      assign wrap = 1'b0;
    end
  endgenerate

  always_ff @(posedge t_clk or negedge r) begin
    if (!r) begin
      state_q <= COPY;
    end else begin
      state_q <= state_d;
    end
  end

  // The word boundary wins over the sticky INVERT state so the next bit starts a fresh word.
  always_comb begin
    state_d = state_q;
    if (state_q == COPY && i) begin
      state_d = INVERT;
    end
    if (wrap) begin
      state_d = COPY;
    end
  end

  // Mealy output uses the pre-edge state, so the first 1 passes through unchanged.
  assign y     = i ^ (state_q == INVERT);
  assign state = state_q;

endmodule

// File: tb/tb_invert.sv
// Directed bench for invert: one unbounded instance and one with WORD_LEN=4 share the serial input.
module tb_invert;
  import invert_pkg::*;

  logic   t_clk;
  logic   r;
  logic   i;
  logic   y0;
  logic   y4;
  state_t state0;
  state_t state4;

  int errors = 0;
  int checks = 0;

  invert #(.WORD_LEN(0)) dut0 (
    .t_clk(t_clk),
    .r    (r),
    .i    (i),
    .y    (y0),
    .state(state0)
  );

  invert #(.WORD_LEN(4)) dut4 (
    .t_clk(t_clk),
    .r    (r),
    .i    (i),
    .y    (y4),
    .state(state4)
  );

  // clock / reset
  initial begin
    t_clk = 1'b0;
    forever #5 t_clk = ~t_clk;
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one word LSB first on falling edges; mask bit0 checks dut0, bit1 checks dut4.
  task automatic send_word(input string tag, input int n, input logic [15:0] bits,
                           input logic [15:0] exp0, input logic [15:0] exp4,
                           input logic [1:0] mask);
    for (int k = 0; k < n; k++) begin
      @(negedge t_clk);
      i = bits[k];
      #1;
      if (mask[0]) check($sformatf("%s y0[%0d]", tag, k), y0, exp0[k]);
      if (mask[1]) check($sformatf("%s y4[%0d]", tag, k), y4, exp4[k]);
    end
    @(posedge t_clk);
    #1;
  endtask

  // Short asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    r = 1'b0;
    i = 1'b0;
    #1;
    check("rst state0", logic'(state0), logic'(COPY));
    check("rst state4", logic'(state4), logic'(COPY));
    #1;
    r = 1'b1;
  endtask

  initial begin
    logic [2:0] rst_bits;
    r = 1'b0;
    i = 1'b0;
    rst_bits = 3'b101;

    // reset held: y follows i, state stays COPY across edges
    for (int k = 0; k < 3; k++) begin
      @(negedge t_clk);
      i = rst_bits[k];
      #1;
      check($sformatf("hold y0[%0d]", k), y0, rst_bits[k]);
      check($sformatf("hold y4[%0d]", k), y4, rst_bits[k]);
      @(posedge t_clk);
      #1;
      check($sformatf("hold state0[%0d]", k), logic'(state0), logic'(COPY));
      check($sformatf("hold state4[%0d]", k), logic'(state4), logic'(COPY));
    end
    i = 1'b0;
    #1;
    r = 1'b1;

    // 0b10100 -> 0b01100 (12); dut4 wraps before bit 4, which restarts in COPY
    send_word("basic", 5, 16'b10100, 16'b01100, 16'b11100, 2'b11);
    check("basic state0", logic'(state0), logic'(INVERT));

    do_reset();
    send_word("zero", 4, 16'b0000, 16'b0000, 16'b0000, 2'b11);
    check("zero state0", logic'(state0), logic'(COPY));
    check("zero state4", logic'(state4), logic'(COPY));

    do_reset();
    send_word("mneg", 4, 16'b1000, 16'b1000, 16'b1000, 2'b11);
    check("mneg state0", logic'(state0), logic'(INVERT));
    check("mneg state4", logic'(state4), logic'(COPY));

    // continuing: dut0 stays inverted, dut4 has started a new word
    send_word("sticky", 4, 16'b0011, 16'b1100, 16'b1101, 2'b11);
    check("sticky state0", logic'(state0), logic'(INVERT));
    check("sticky state4", logic'(state4), logic'(COPY));

    // mid-word reset aborts the word
    do_reset();
    send_word("mid pre", 2, 16'b01, 16'b11, 16'b11, 2'b11);
    check("mid pre state0", logic'(state0), logic'(INVERT));
    do_reset();
    #1;
    check("mid post y0", y0, i);
    send_word("mid post", 3, 16'b110, 16'b010, 16'b010, 2'b11);

    // auto-restart every 4 bits on dut4; dut0 inverts the rest
    do_reset();
    send_word("auto", 8, 16'hFF, 16'b00000001, 16'b00010001, 2'b11);
    check("auto state4", logic'(state4), logic'(COPY));
    check("auto state0", logic'(state0), logic'(INVERT));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
